// File: rtl/sram_pkg.sv
// Shared types and constants for the 8-word SRAM sequencing controller.
package sram_pkg;
  localparam int ADDR_WIDTH         = 3;
  localparam int NUM_WORDS          = 8;
  localparam int NUM_REQ            = 2;
  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRECHARGE,
    ST_WORDLINE,
    ST_SENSE,
    ST_DONE
  } sram_state_t;
endpackage

// File: rtl/sram_controller_rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the requester not served last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       pick_vld,
  output logic       pick
);
  always_comb begin
    pick_vld = |req;
    if (&req) pick = ~last;
    else      pick = req[1];
  end
endmodule

// File: rtl/sram_controller.sv
// Sequences arbitrated SRAM reads/writes through precharge, word-line and sense phases.
module sram_controller
  import sram_pkg::*;
#(
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic [NUM_REQ-1:0]    grant,
  output logic [NUM_REQ-1:0]    done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  valid,
  output logic                  precharge,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] bitline_data,
  output logic                  sense_enable,
  input  logic [DATA_WIDTH-1:0] sense_data
);
  localparam int              CNT_W    = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  sram_state_t           state, state_d;
  logic                  owner, last_win;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [CNT_W-1:0]      cnt;
  logic                  pick_vld, pick, accept;
  logic [NUM_REQ-1:0]    owner_oh;

  rr_arbiter2 u_arb (
    .req      (req),
    .last     (last_win),
    .pick_vld (pick_vld),
    .pick     (pick)
  );

  always_comb begin
    state_d = state;
    accept  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_PRECHARGE;
          accept  = 1'b1;
        end
      end
      ST_PRECHARGE: state_d = ST_WORDLINE;
      ST_WORDLINE: begin
        if (cnt == CNT_LAST) state_d = we_q ? ST_DONE : ST_SENSE;
      end
      ST_SENSE: state_d = ST_DONE;
      // Re-arbitrating here lets a pending request start without an IDLE gap.
      ST_DONE: begin
        if (pick_vld) begin
          state_d = ST_PRECHARGE;
          accept  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      owner    <= 1'b0;
      last_win <= 1'b1;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt      <= '0;
    end else begin
      state <= state_d;
      if (accept) begin
        owner    <= pick;
        last_win <= pick;
        addr_q   <= pick ? addr1 : addr0;
        we_q     <= we[pick];
        wdata_q  <= pick ? wdata1 : wdata0;
      end
      cnt <= (state == ST_WORDLINE) ? cnt + 1'b1 : '0;
      if (state == ST_SENSE) rdata_q <= sense_data;
    end
  end

  assign owner_oh     = {owner, ~owner};
  assign grant        = (state == ST_PRECHARGE) ? owner_oh : '0;
  assign done         = (state == ST_DONE) ? owner_oh : '0;
  assign busy         = (state != ST_IDLE);
  assign address      = addr_q;
  assign precharge    = (state == ST_PRECHARGE);
  assign valid        = (state == ST_WORDLINE) || (state == ST_SENSE);
  assign write_enable = (state == ST_WORDLINE) && we_q;
  assign bitline_data = write_enable ? wdata_q : '0;
  assign sense_enable = (state == ST_SENSE);
  assign rdata        = rdata_q;
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: per-cycle comparison against a queue-of-phases reference model.
module tb_sram_controller;
  localparam int AC = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, we;
  logic [2:0] addr0, addr1;
  logic [7:0] wdata0, wdata1, sense_data;

  logic [1:0] grant, done;
  logic [7:0] rdata, bitline_data;
  logic [2:0] address;
  logic       busy, valid, precharge, write_enable, sense_enable;

  logic [1:0] g1, d1;
  logic [7:0] rdata1, bl1;
  logic [2:0] address1;
  logic       busy1, valid1, pre1, we1o, se1;

  always #5 clk = ~clk;

  sram_controller #(.DATA_WIDTH(8), .ACCESS_CYCLES(AC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .grant(grant), .done(done), .rdata(rdata),
    .busy(busy), .address(address), .valid(valid), .precharge(precharge),
    .write_enable(write_enable), .bitline_data(bitline_data),
    .sense_enable(sense_enable), .sense_data(sense_data)
  );

  sram_controller #(.DATA_WIDTH(8), .ACCESS_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .grant(g1), .done(d1), .rdata(rdata1),
    .busy(busy1), .address(address1), .valid(valid1), .precharge(pre1),
    .write_enable(we1o), .bitline_data(bl1),
    .sense_enable(se1), .sense_data(sense_data)
  );

  typedef struct packed {
    logic       pre, vld, wen, sen;
    logic [2:0] adr;
    logic [7:0] bl;
    logic [1:0] gnt, dn;
  } rec_t;

  rec_t       q[$];
  logic       m_last;
  logic [2:0] m_addr;
  logic [7:0] m_rdata;
  logic [1:0] outst;
  bit         hold;
  int         n_cmp = 0, n_bad = 0, n_txn = 0, start0 = 0;
  int         gi = 0, idle_seen = 0;
  logic [1:0] gseq [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic rec_t idle_rec();
    rec_t r;
    r = '0;
    r.adr = m_addr;
    return r;
  endfunction

  // Each accepted access expands into the exact list of cycles it must occupy.
  task automatic push_txn(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    rec_t x;
    x = '0; x.adr = a; x.pre = 1'b1; x.gnt = r ? 2'b10 : 2'b01;
    q.push_back(x);
    for (int i = 0; i < AC; i++) begin
      x = '0; x.adr = a; x.vld = 1'b1; x.wen = w; x.bl = w ? d : 8'h00;
      q.push_back(x);
    end
    if (!w) begin
      x = '0; x.adr = a; x.vld = 1'b1; x.sen = 1'b1;
      q.push_back(x);
    end
    x = '0; x.adr = a; x.dn = r ? 2'b10 : 2'b01;
    q.push_back(x);
  endtask

  task automatic model_edge();
    logic w;
    if (q.size() > 0 && q[0].sen) m_rdata = sense_data;
    if (q.size() > 0 && q[0].dn != 2'b00) outst = outst & ~q[0].dn;
    if (q.size() > 1) q.delete(0);
    else begin
      if (q.size() == 1) q.delete(0);
      if (req != 2'b00) begin
        w = (req == 2'b11) ? ~m_last : req[1];
        m_last = w;
        m_addr = w ? addr1 : addr0;
        push_txn(w, we[w], m_addr, w ? wdata1 : wdata0);
        n_txn++;
      end
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = 1'b1; m_addr = '0; m_rdata = '0; outst = '0; req = '0;
  endtask

  task automatic compare_all();
    rec_t e;
    e = (q.size() > 0) ? q[0] : idle_rec();
    check("grant", 32'(grant), 32'(e.gnt));
    check("done", 32'(done), 32'(e.dn));
    check("busy", 32'(busy), 32'(q.size() > 0));
    check("address", 32'(address), 32'(e.adr));
    check("valid", 32'(valid), 32'(e.vld));
    check("precharge", 32'(precharge), 32'(e.pre));
    check("write_enable", 32'(write_enable), 32'(e.wen));
    check("sense_enable", 32'(sense_enable), 32'(e.sen));
    check("bitline_data", 32'(bitline_data), 32'(e.bl));
    check("rdata", 32'(rdata), 32'(m_rdata));
    check("pre_and_valid", 32'(precharge & valid), 32'd0);
    check("we_and_se", 32'(write_enable & sense_enable), 32'd0);
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("done_onehot0", 32'($onehot0(done)), 32'd1);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    if (!hold && q.size() > 0) req = req & ~q[0].gnt;
    compare_all();
  endtask

  task automatic raise(input logic r, input logic w, input logic [2:0] a, input logic [7:0] d);
    req[r] = 1'b1;
    we[r]  = w;
    if (r) begin addr1 = a; wdata1 = d; end
    else   begin addr0 = a; wdata0 = d; end
    outst[r] = 1'b1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; sense_data = '0; hold = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #2 compare_all();
    #9 rst_n = 1'b1;

    // Single write from requester 0; the AC=1 instance finishes one cycle sooner.
    raise(1'b0, 1'b1, 3'd5, 8'hA5);
    step();
    check("wr_grant", 32'(grant), 32'd1);
    check("ac1_wr_grant", 32'(g1), 32'd1);
    check("ac1_wr_pre", 32'(pre1), 32'd1);
    for (int k = 1; k <= 1 + AC; k++) begin
      step();
      check("wr_done", 32'(done), 32'((k == 1 + AC) ? 1 : 0));
      check("ac1_wr_done", 32'(d1), 32'((k == 2) ? 1 : 0));
      check("ac1_wr_we", 32'(we1o), 32'((k == 1) ? 1 : 0));
      check("ac1_wr_bl", 32'(bl1), 32'((k == 1) ? 8'hA5 : 8'h00));
      check("ac1_wr_valid", 32'(valid1), 32'((k == 1) ? 1 : 0));
    end
    step();
    check("ac1_idle", 32'(busy1), 32'd0);

    // Single read from requester 1 with fixed sense data.
    sense_data = 8'h3C;
    raise(1'b1, 1'b0, 3'd3, 8'h00);
    step();
    check("rd_grant", 32'(grant), 32'd2);
    for (int k = 1; k <= 2 + AC; k++) begin
      step();
      check("rd_sense", 32'(sense_enable), 32'((k == 1 + AC) ? 1 : 0));
      check("rd_done", 32'(done), 32'((k == 2 + AC) ? 2 : 0));
      check("ac1_rd_done", 32'(d1), 32'((k == 3) ? 2 : 0));
      check("ac1_rd_se", 32'(se1), 32'((k == 2) ? 1 : 0));
      if (k == 1) check("ac1_rd_addr", 32'(address1), 32'd3);
    end
    sense_data = 8'hFF;
    step(); step();
    check("rd_hold", 32'(rdata), 32'h3C);
    check("ac1_rd_hold", 32'(rdata1), 32'h3C);

    // Contention: both held high from reset, both reading.
    do_reset();
    hold = 1'b1; we = 2'b00; addr0 = 3'd1; addr1 = 3'd2; req = 2'b11; outst = 2'b11;
    for (int k = 0; k < 3 * (3 + AC); k++) begin
      step();
      if (grant != 2'b00 && gi < 3) begin gseq[gi] = grant; gi++; end
      if (!busy) idle_seen++;
    end
    check("cont_g0", 32'(gseq[0]), 32'd1);
    check("cont_g1", 32'(gseq[1]), 32'd2);
    check("cont_g2", 32'(gseq[2]), 32'd1);
    check("cont_no_idle", 32'(idle_seen), 32'd0);
    hold = 1'b0; req = 2'b00; outst = 2'b00;
    for (int k = 0; k < 20 && q.size() > 0; k++) step();
    check("cont_drain", 32'(q.size()), 32'd0);

    // Randomised traffic on both ports.
    start0 = n_txn;
    for (int k = 0; k < 3000 && (n_txn - start0) < 200; k++) begin
      for (int r = 0; r < 2; r++)
        if (!outst[r] && $urandom_range(0, 1) == 1)
          raise(1'(r), 1'($urandom_range(0, 1)), 3'($urandom()), 8'($urandom()));
      sense_data = 8'($urandom());
      step();
    end
    check("random_budget", 32'((n_txn - start0) >= 200), 32'd1);
    for (int k = 0; k < 40 && (q.size() > 0 || outst != 2'b00); k++) step();
    check("random_drain", 32'(outst), 32'd0);

    // Reset during the word-line phase of a write.
    raise(1'b0, 1'b1, 3'd6, 8'h5A);
    step();
    step();
    check("mid_in_wl", 32'(write_enable), 32'd1);
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all();
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    sense_data = 8'h77;
    raise(1'b0, 1'b0, 3'd0, 8'h00);
    step();
    check("post_rst_grant", 32'(grant), 32'd1);
    for (int k = 1; k <= 2 + AC; k++) begin
      step();
      check("post_rst_done", 32'(done), 32'((k == 2 + AC) ? 1 : 0));
    end
    step();
    check("post_rst_rdata", 32'(rdata), 32'h77);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sram_controller.md
# sram_controller

Sequencing controller for the 8-word SRAM array. Arbitrates between two requesters (round-robin) and runs each accepted read or write through the precharge → word-line → sense cycle sequence. Drives the address/valid pair of the 3-to-8 word-line decoder, plus precharge, write-enable and sense-enable for the bit-line circuitry.

## Interface
Parameters:
- DATA_WIDTH, 8, word width of the array
- ACCESS_CYCLES, 2, cycles the word line is held active (≥1)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  2  request per requester; held high until granted
- we  in  2  per requester: 1 = write, 0 = read; valid with req
- addr0, addr1  in  3  word address per requester
- wdata0, wdata1  in  DATA_WIDTH  write data per requester
- grant  out  2  one-hot, one-cycle pulse; request accepted and latched
- done  out  2  one-hot, one-cycle pulse; access complete
- rdata  out  DATA_WIDTH  read result; valid while done is high, held until the next read completes
- busy  out  1  high in every state except IDLE
- address  out  3  to decoder address
- valid  out  1  to decoder valid (word-line enable)
- precharge  out  1  bit-line precharge enable
- write_enable  out  1  bit-line write drivers enable
- bitline_data  out  DATA_WIDTH  data to write drivers
- sense_enable  out  1  sense amplifier enable
- sense_data  in  DATA_WIDTH  sense amplifier outputs

## Operation
- States: IDLE, PRECHARGE, WORDLINE, SENSE, DONE.
- IDLE: if any req, arbitrate → PRECHARGE. Latch winner's addr, we, wdata. Pulse grant[winner] in the PRECHARGE cycle.
- Arbitration: a single request wins. If both are requesting, the requester not served last wins. The last-winner register resets so that requester 0 wins the first tie.
- PRECHARGE: 1 cycle, precharge=1, valid=0 → WORDLINE.
- WORDLINE: ACCESS_CYCLES cycles, valid=1. On writes, write_enable=1 and bitline_data=latched wdata. Exit: write → DONE, read → SENSE.
- SENSE (reads only): 1 cycle, valid=1, sense_enable=1. rdata captures sense_data at the end of the cycle → DONE.
- DONE: 1 cycle, done[owner]=1.
  - If any req is pending, arbitrate and go directly to PRECHARGE. This gives back-to-back accesses with no IDLE gap.
  - Otherwise go to IDLE.
- Invariants:
  - precharge and valid are never both high.
  - write_enable and sense_enable are never both high.
  - address stays constant from PRECHARGE through DONE.
  - bitline_data is 0 except when write_enable is high.
- Requests arriving while busy are not dropped. They are evaluated at the next IDLE or DONE decision.
- A requester may re-raise req in the cycle after its done. It competes normally under round-robin.

## Timing
- Reset (async assert): state=IDLE. All outputs 0, including grant, done, rdata, address, valid, precharge, write_enable, sense_enable, bitline_data and busy. Last-winner points to requester 1.
- Reset mid-access: the latched request is discarded and no done pulse is issued. Deassertion is synchronised by the standard reset release; the first request may be accepted on the first edge after release.
- req sampled at edge T in IDLE → grant at T+1 (PRECHARGE).
- WORDLINE runs T+2 … T+1+ACCESS_CYCLES.
- Read: SENSE at T+2+ACCESS_CYCLES, done at T+3+ACCESS_CYCLES. Default: done at T+5.
- Write: done at T+2+ACCESS_CYCLES. Default: done at T+4.
- Back-to-back throughput (default): read every 5 cycles, write every 4 cycles.

## Structure
- Shared package sram_pkg:
  - state enum sram_state_t
  - ADDR_WIDTH=3
  - NUM_WORDS=8
  - NUM_REQ=2
  - default DATA_WIDTH
- Sub-module rr_arbiter2: combinational two-way round-robin pick from req and the last-winner register. The last-winner register lives in sram_controller and updates on grant.
- The WORDLINE cycle counter is local to sram_controller. Its width is $clog2(ACCESS_CYCLES+1).

## Test plan
- Single write: req0=1, we0=1, addr0=5, wdata0=0xA5 → grant0 at T+1. WORDLINE at T+2..T+3 with address=5, valid=1, write_enable=1, bitline_data=0xA5. done0 at T+4.
- Single read: req1=1, we1=0, addr1=3, sense_data=0x3C during SENSE → sense_enable at T+4, done1 at T+5, rdata=0x3C held afterwards.
- Contention: req0 and req1 both high from reset, both reads → grant0 first. Next grant1 is issued directly from DONE with no IDLE cycle. Then grant0 again if both remain high.
- Sequencing invariants under 200 random reads/writes on both ports → precharge&valid, write_enable&sense_enable and multiple-bit grant/done are never observed. Every grant is followed by exactly one done for the same requester.
- Reset mid-access: assert rst_n=0 during WORDLINE of a write → all outputs 0 immediately and no done pulse. After release, a new read of addr 0 completes normally with done at T+5.
- ACCESS_CYCLES=1 build: write done at T+3, read done at T+4.
